// File: rtl/memory_game_n.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// memory_game_n : parametrised sequence-repeat memory game
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module memory_game_n #(
  parameter int          NUM_SW      = 16,
  parameter int          MAX_LEN     = 8,
  parameter int          SHOW_CYCLES = 4,
  parameter int          LIVES       = 3,
  parameter int          SCORE_W     = 4,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               bIn,
  input  logic [NUM_SW-1:0]  switchIn,
  input  logic               gameTimeout,
  output logic [SCORE_W-1:0] score,
  output logic [NUM_SW-1:0]  redLight,
  output logic [LIVES-1:0]   lives,
  output logic               showing,
  output logic               endGame
);

  localparam int c_IW = (NUM_SW > 1) ? $clog2(NUM_SW) : 1;
  localparam int c_LW = $clog2(MAX_LEN + 1);
  localparam int c_PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int c_CW = $clog2(SHOW_CYCLES + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADD      = 3'd1;
  localparam logic [2:0] S_SHOW_ON  = 3'd2;
  localparam logic [2:0] S_SHOW_OFF = 3'd3;
  localparam logic [2:0] S_INPUT    = 3'd4;
  localparam logic [2:0] S_END      = 3'd5;

  logic [2:0]         r_state, w_state_nxt;
  logic [15:0]        r_lfsr;
  logic               r_bprev, r_press;
  logic [c_IW-1:0]    r_seq [MAX_LEN];
  logic [c_LW-1:0]    r_len, w_len_nxt;
  logic [c_LW-1:0]    r_pos, w_pos_nxt, w_pos_inc;
  logic [c_CW-1:0]    r_cnt, w_cnt_nxt;
  logic [SCORE_W-1:0] r_score, w_score_nxt;
  logic [LIVES-1:0]   r_lives, w_lives_nxt, w_lives_dec;
  logic [NUM_SW-1:0]  r_red, w_red_nxt;
  logic               r_showing, w_showing_nxt;
  logic               r_end, w_end_nxt;
  logic               w_seq_we;
  logic [c_IW-1:0]    w_v, w_idx;
  logic               w_last, w_correct, w_on_done, w_timeout;

  function automatic logic [NUM_SW-1:0] onehot(input logic [c_IW-1:0] i);
    logic [NUM_SW-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Fold out-of-range LFSR values back into 0..NUM_SW-1
  assign w_v         = r_lfsr[c_IW-1:0];
  assign w_idx       = (int'(w_v) >= NUM_SW) ? (w_v - NUM_SW[c_IW-1:0]) : w_v;
  assign w_pos_inc   = r_pos + 1'b1;
  assign w_last      = (r_pos == r_len - c_LW'(1));
  assign w_correct   = (switchIn == onehot(r_seq[r_pos[c_PW-1:0]]));
  assign w_on_done   = (r_cnt == c_CW'(SHOW_CYCLES - 1));
  assign w_lives_dec = r_lives >> 1;
  assign w_timeout   = gameTimeout && (r_state != S_END);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_lfsr    <= SEED;
      r_bprev   <= 1'b0;
      r_press   <= 1'b0;
      r_len     <= '0;
      r_pos     <= '0;
      r_cnt     <= '0;
      r_score   <= '0;
      r_lives   <= '1;
      r_red     <= '0;
      r_showing <= 1'b0;
      r_end     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lfsr    <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      r_bprev   <= bIn;
      r_press   <= bIn & ~r_bprev;
      r_len     <= w_len_nxt;
      r_pos     <= w_pos_nxt;
      r_cnt     <= w_cnt_nxt;
      r_score   <= w_score_nxt;
      r_lives   <= w_lives_nxt;
      r_red     <= w_red_nxt;
      r_showing <= w_showing_nxt;
      r_end     <= w_end_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_seq_we) begin
      r_seq[r_len[c_PW-1:0]] <= w_idx;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = S_END;
    end else if (enable) begin
      case (r_state)
        S_IDLE:     if (r_press) w_state_nxt = S_ADD;
        S_ADD:      w_state_nxt = S_SHOW_ON;
        S_SHOW_ON:  if (w_on_done) w_state_nxt = S_SHOW_OFF;
        S_SHOW_OFF: w_state_nxt = w_last ? S_INPUT : S_SHOW_ON;
        S_INPUT: begin
          if (r_press) begin
            if (w_correct) begin
              if (w_last) w_state_nxt = (r_len == c_LW'(MAX_LEN)) ? S_END : S_ADD;
            end else begin
              w_state_nxt = (w_lives_dec == '0) ? S_END : S_SHOW_ON;
            end
          end
        end
        default:    w_state_nxt = S_END;
      endcase
    end
  end

  always_comb begin
    w_seq_we      = 1'b0;
    w_len_nxt     = r_len;
    w_pos_nxt     = r_pos;
    w_cnt_nxt     = r_cnt;
    w_score_nxt   = r_score;
    w_lives_nxt   = r_lives;
    w_red_nxt     = r_red;
    w_showing_nxt = r_showing;
    w_end_nxt     = r_end;
    if (w_timeout) begin
      w_red_nxt     = '0;
      w_showing_nxt = 1'b0;
      w_end_nxt     = 1'b1;
    end else if (enable) begin
      case (r_state)
        S_ADD: begin
          w_seq_we      = 1'b1;
          w_len_nxt     = r_len + 1'b1;
          w_pos_nxt     = '0;
          w_cnt_nxt     = '0;
          w_showing_nxt = 1'b1;
          // On the first round seq[0] is being written this very edge
          w_red_nxt     = (r_len == '0) ? onehot(w_idx) : onehot(r_seq[0]);
        end
        S_SHOW_ON: begin
          if (w_on_done) begin
            w_red_nxt = '0;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_SHOW_OFF: begin
          if (w_last) begin
            w_pos_nxt     = '0;
            w_showing_nxt = 1'b0;
          end else begin
            w_pos_nxt = w_pos_inc;
            w_red_nxt = onehot(r_seq[w_pos_inc[c_PW-1:0]]);
          end
        end
        S_INPUT: begin
          if (r_press) begin
            if (w_correct) begin
              if (w_last) begin
                w_pos_nxt = '0;
                if (r_score != '1) w_score_nxt = r_score + 1'b1;
                if (r_len == c_LW'(MAX_LEN)) w_end_nxt = 1'b1;
              end else begin
                w_pos_nxt = w_pos_inc;
              end
            end else begin
              w_lives_nxt = w_lives_dec;
              if (w_lives_dec == '0) begin
                w_end_nxt = 1'b1;
              end else begin
                w_pos_nxt     = '0;
                w_cnt_nxt     = '0;
                w_showing_nxt = 1'b1;
                w_red_nxt     = onehot(r_seq[0]);
              end
            end
          end
        end
        S_END: begin
          w_red_nxt     = '0;
          w_showing_nxt = 1'b0;
          w_end_nxt     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign score    = r_score;
  assign redLight = r_red;
  assign lives    = r_lives;
  assign showing  = r_showing;
  assign endGame  = r_end;

endmodule
`default_nettype wire

// File: tb/tb_memory_game_n.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_memory_game_n : directed/randomised bench for memory_game_n
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_memory_game_n;

  localparam int NSW = 16;
  localparam int ML  = 4;
  localparam int SC  = 4;
  localparam int LV  = 3;
  localparam int SW  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           enable = 1'b0;
  logic           bIn = 1'b0;
  logic [NSW-1:0] switchIn = '0;
  logic           gameTimeout = 1'b0;
  logic [SW-1:0]  score;
  logic [NSW-1:0] redLight;
  logic [LV-1:0]  lives;
  logic           showing;
  logic           endGame;

  int vectors = 0;
  int miscompares = 0;
  int q[$];
  int rec[$];
  int exp_score;
  int exp_lives;

  memory_game_n #(
    .NUM_SW(NSW), .MAX_LEN(ML), .SHOW_CYCLES(SC), .LIVES(LV), .SCORE_W(SW), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .bIn(bIn), .switchIn(switchIn),
    .gameTimeout(gameTimeout), .score(score), .redLight(redLight), .lives(lives),
    .showing(showing), .endGame(endGame)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NSW-1:0] hot(input int i);
    logic [NSW-1:0] v;
    v = '0;
    if (i >= 0 && i < NSW) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int idx_of(input logic [NSW-1:0] v);
    for (int i = 0; i < NSW; i++) if (v[i]) return i;
    return -1;
  endfunction

  // lives[i] is set exactly when more than i lives remain
  function automatic logic [LV-1:0] therm(input int n);
    logic [LV-1:0] t;
    t = '0;
    for (int i = 0; i < LV; i++) if (n > i) t[i] = 1'b1;
    return t;
  endfunction

  task automatic check_status(input string tag);
    chk({tag, "_score"}, score, exp_score);
    chk({tag, "_lives"}, lives, therm(exp_lives));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enable      = 1'($urandom);
      bIn         = 1'($urandom);
      switchIn    = NSW'($urandom);
      gameTimeout = 1'($urandom);
      tick();
    end
    chk("rst_score", score, 0);
    chk("rst_red", redLight, 0);
    chk("rst_lives", lives, 3'b111);
    chk("rst_showing", showing, 0);
    chk("rst_end", endGame, 0);
    enable = 1'b0; bIn = 1'b0; switchIn = '0; gameTimeout = 1'b0;
    tick();
    rst = 1'b1;
    q.delete();
    exp_score = 0;
    exp_lives = LV;
    enable = 1'b1;
    repeat (10) tick();
    chk("idle_red", redLight, 0);
    chk("idle_showing", showing, 0);
    chk("idle_end", endGame, 0);
  endtask

  task automatic press();
    bIn = 1'b1;
    tick();
    bIn = 1'b0;
  endtask

  task automatic start();
    enable = 1'b1;
    press();
    tick();
    chk("start_add_dark", redLight, 0);
    tick();
    chk("start_first_light", redLight != '0, 1);
    chk("start_showing", showing, 1);
  endtask

  task automatic capture(input int n);
    int w;
    int on;
    logic [NSW-1:0] lt;
    rec.delete();
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (redLight == '0 && w < 30) begin tick(); w++; end
      chk("light_wait_bound", w < 30, 1);
      lt = redLight;
      chk("light_onehot", $onehot(lt), 1);
      chk("light_showing", showing, 1);
      on = 0;
      while (redLight == lt && on < 50) begin on++; tick(); end
      chk("light_on_cycles", on, SC);
      chk("light_off_gap", redLight, 0);
      chk("gap_showing", showing, 1);
      rec.push_back(idx_of(lt));
      tick();
      if (i < n - 1) chk("next_light_follows", redLight != '0, 1);
      else           chk("showing_falls", showing, 0);
    end
  endtask

  task automatic answer(input logic [NSW-1:0] sw);
    switchIn = sw;
    press();
    tick();
    switchIn = '0;
  endtask

  task automatic play_round(input int r);
    capture(r);
    for (int j = 0; j < r - 1; j++) chk("replay_prefix", rec[j], q[j]);
    q.push_back(rec[r-1]);
    for (int j = 0; j < r; j++) answer(hot(q[j]));
    exp_score++;
    check_status("round");
  endtask

  task automatic check_replay();
    capture(q.size());
    for (int j = 0; j < q.size(); j++) chk("replay_same", rec[j], q[j]);
  endtask

  initial begin
    int wrong;
    int w;
    int on;
    logic [NSW-1:0] sw;
    logic [NSW-1:0] lt;

    // Basic play and losing all lives
    do_reset();
    start();
    play_round(1);
    capture(2);
    chk("grow_first_same", rec[0], q[0]);
    q.push_back(rec[1]);
    wrong = (q[0] + int'($urandom_range(1, NSW - 1))) % NSW;
    answer(hot(wrong));
    exp_lives = 2;
    check_status("miss1");
    chk("miss1_end", endGame, 0);
    check_replay();
    wrong = (q[0] + int'($urandom_range(1, NSW - 1))) % NSW;
    answer(hot(q[0]) | hot(wrong));
    exp_lives = 1;
    check_status("miss2_extra");
    check_replay();
    sw = NSW'($urandom);
    if (sw == hot(q[0])) sw = '0;
    answer(sw);
    exp_lives = 0;
    check_status("miss3");
    chk("miss3_end", endGame, 1);
    chk("miss3_red", redLight, 0);
    chk("miss3_showing", showing, 0);
    answer(hot(q[0]));
    repeat (5) tick();
    check_status("end_hold");
    chk("end_hold_end", endGame, 1);
    chk("end_hold_red", redLight, 0);

    // Win by completing MAX_LEN rounds
    do_reset();
    start();
    for (int r = 1; r <= ML; r++) play_round(r);
    chk("win_end", endGame, 1);
    chk("win_red", redLight, 0);
    chk("win_score", score, ML);
    repeat (3) tick();
    chk("win_hold_red", redLight, 0);

    // Timeout pulse during playback, with enable low
    do_reset();
    start();
    play_round(1);
    w = 0;
    while (redLight == '0 && w < 30) begin tick(); w++; end
    chk("to_wait_bound", w < 30, 1);
    tick();
    enable = 1'b0;
    gameTimeout = 1'b1;
    tick();
    gameTimeout = 1'b0;
    chk("to_end", endGame, 1);
    chk("to_red", redLight, 0);
    chk("to_showing", showing, 0);
    check_status("to_held");
    enable = 1'b1;

    // Freeze mid-playback
    do_reset();
    start();
    lt = redLight;
    tick();
    chk("frz_pre", redLight, lt);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("frz_red", redLight, lt);
      chk("frz_showing", showing, 1);
    end
    enable = 1'b1;
    on = 0;
    tick();
    while (redLight == lt && on < 50) begin on++; tick(); end
    chk("frz_remaining", on, SC - 2);
    chk("frz_off", redLight, 0);

    // Asynchronous reset while waiting for input
    do_reset();
    start();
    play_round(1);
    play_round(2);
    capture(3);
    #1 rst = 1'b0;
    #1;
    chk("arst_score", score, 0);
    chk("arst_red", redLight, 0);
    chk("arst_lives", lives, 3'b111);
    chk("arst_showing", showing, 0);
    chk("arst_end", endGame, 0);
    tick();
    rst = 1'b1;
    q.delete();
    exp_score = 0;
    exp_lives = LV;
    tick();
    start();
    capture(1);
    chk("fresh_len", rec.size(), 1);
    check_status("fresh");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
